// File: rtl/pito_mvu_csr_launcher.sv
// pito_mvu_csr_launcher
//   Per-hart MVU CSR bank and launch sequencer. Each hart has three copies of its
//   configuration:
//     - a shadow copy that CSR writes update,
//     - a one-deep queued copy that a command write snapshots the shadow into,
//     - an active copy that drives mvu_cfg_o.
//   A small FSM per hart launches the queued job, waits for the ack, then waits
//   for the completion irq.
//
//   Register map (index = csr_addr_i - CSR_BASE):
//     0 wbaseaddr, 1 ibaseaddr, 2 obaseaddr,
//     then NUM_DIMS each of wstride, istride, ostride, wlength, ilength, olength,
//     then precision, quant, command (write-only), status.
//   Status bits: [0] busy, [1] pending, [2] done (W1C), [3] overflow (W1C).
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   csr_we_i/re_i     CSR write/read strobes for hart csr_hart_i at csr_addr_i
//   csr_wdata_i       CSR write data
//   csr_rdata_o       read data, valid one cycle after csr_re_i
//   csr_rvalid_o      read data valid
//   mvu_start_o       per-hart launch request (level until acked)
//   mvu_start_ack_i   per-hart launch accept
//   mvu_irq_i         per-hart job-complete pulse
//   mvu_cfg_o         active config, NREGS words per hart, hart 0 in LSBs
//   irq_o             per-hart interrupt (mirrors status.done)
module pito_mvu_csr_launcher #(
    parameter int unsigned NUM_HARTS = 8,
    parameter int unsigned NUM_DIMS  = 4,
    parameter int unsigned DATA_W    = 32,
    parameter logic [11:0] CSR_BASE  = 12'hF20,
    // Config words (5 + 6*NUM_DIMS) plus the command and status slots.
    parameter int unsigned NREGS     = 7 + 6 * NUM_DIMS,
    localparam int unsigned HW       = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              csr_we_i,
    input  logic                              csr_re_i,
    input  logic [HW-1:0]                     csr_hart_i,
    input  logic [11:0]                       csr_addr_i,
    input  logic [DATA_W-1:0]                 csr_wdata_i,
    output logic [DATA_W-1:0]                 csr_rdata_o,
    output logic                              csr_rvalid_o,
    output logic [NUM_HARTS-1:0]              mvu_start_o,
    input  logic [NUM_HARTS-1:0]              mvu_start_ack_i,
    input  logic [NUM_HARTS-1:0]              mvu_irq_i,
    output logic [NUM_HARTS*NREGS*DATA_W-1:0] mvu_cfg_o,
    output logic [NUM_HARTS-1:0]              irq_o
);

    localparam int unsigned NCFG       = NREGS - 2;
    localparam logic [11:0] IDX_CMD    = 12'(NCFG);
    localparam logic [11:0] IDX_STATUS = 12'(NCFG + 1);

    typedef enum logic [1:0] {StIdle, StStart, StBusy, StDone} state_e;

    logic [11:0]       idx;
    logic [DATA_W-1:0] rd_word [NUM_HARTS];

    // Addresses below CSR_BASE wrap to large indices and fall out of range.
    assign idx = csr_addr_i - CSR_BASE;

    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
        logic [DATA_W-1:0] shadow_q [NCFG];
        logic [DATA_W-1:0] queued_q [NCFG];
        logic [DATA_W-1:0] active_q [NCFG];
        state_e            state_q;
        logic              pending_q, done_q, overflow_q;
        logic              sel, cmd_go, st_wr, launch;
        logic [DATA_W-1:0] status;

        assign sel    = csr_we_i && (csr_hart_i == HW'(h));
        assign cmd_go = sel && (idx == IDX_CMD) && csr_wdata_i[0];
        assign st_wr  = sel && (idx == IDX_STATUS);
        assign launch = (state_q == StIdle) && pending_q;
        assign status = DATA_W'({overflow_q, done_q, pending_q, state_q != StIdle});

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < NCFG; i++) begin
                    shadow_q[i] <= '0;
                    queued_q[i] <= '0;
                    active_q[i] <= '0;
                end
                state_q    <= StIdle;
                pending_q  <= 1'b0;
                done_q     <= 1'b0;
                overflow_q <= 1'b0;
            end else begin
                for (int i = 0; i < NCFG; i++) begin
                    if (sel && idx == 12'(i)) shadow_q[i] <= csr_wdata_i;
                end

                // A launch in the same cycle frees the slot, so the new command
                // queues instead of overflowing.
                if (cmd_go) begin
                    if (pending_q && !launch) begin
                        overflow_q <= 1'b1;
                    end else begin
                        for (int i = 0; i < NCFG; i++) queued_q[i] <= shadow_q[i];
                        pending_q <= 1'b1;
                    end
                end else if (launch) begin
                    pending_q <= 1'b0;
                end

                if (st_wr && csr_wdata_i[3] && !(cmd_go && pending_q && !launch)) begin
                    overflow_q <= 1'b0;
                end

                // Completion set wins over a simultaneous W1C.
                if (state_q == StDone) begin
                    done_q <= 1'b1;
                end else if (st_wr && csr_wdata_i[2]) begin
                    done_q <= 1'b0;
                end

                unique case (state_q)
                    StIdle: begin
                        if (pending_q) begin
                            for (int i = 0; i < NCFG; i++) active_q[i] <= queued_q[i];
                            state_q <= StStart;
                        end
                    end
                    StStart: if (mvu_start_ack_i[h]) state_q <= StBusy;
                    StBusy:  if (mvu_irq_i[h]) state_q <= StDone;
                    StDone:  state_q <= StIdle;
                    default: state_q <= StIdle;
                endcase
            end
        end

        assign mvu_start_o[h] = (state_q == StStart);
        assign irq_o[h]       = done_q;

        for (genvar i = 0; i < NCFG; i++) begin : g_cfg
            assign mvu_cfg_o[(h*NREGS+i)*DATA_W +: DATA_W] = active_q[i];
        end
        assign mvu_cfg_o[(h*NREGS+NCFG)*DATA_W +: 2*DATA_W] = '0;

        always_comb begin
            rd_word[h] = '0;
            for (int i = 0; i < NCFG; i++) begin
                if (idx == 12'(i)) rd_word[h] = shadow_q[i];
            end
            if (idx == IDX_STATUS) rd_word[h] = status;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csr_rdata_o  <= '0;
            csr_rvalid_o <= 1'b0;
        end else begin
            csr_rvalid_o <= csr_re_i;
            csr_rdata_o  <= csr_re_i ? rd_word[csr_hart_i] : '0;
        end
    end

endmodule
